// File: rtl/dma_channel_scheduler.sv
// dma_channel_scheduler
//   Two-channel round-robin scheduler for one DMA engine (read master and
//   write master joined by the data FIFO). It checks the winning channel's
//   descriptor, latches it, pulses both master starts and then waits for a
//   fresh rising edge on both master done levels. It reports done or error
//   per channel, raises a sticky interrupt and accumulates the byte count.
//   A transfer that stays in WAIT for TIMEOUT_CYCLES is declared hung, and
//   the engine then stays parked until reset.
//
// Ports
//   clk, reset_n               system clock, asynchronous active-low reset
//   i_chN_req                  level request, held until done/err (N=0,1)
//   i_chN_src_addr/dst_addr    4-byte aligned byte addresses
//   i_chN_len                  transfer bytes, nonzero multiple of 4
//   o_chN_busy                 channel N owns the engine (LAUNCH..DONE)
//   o_chN_done / o_chN_err     one-cycle completion / rejection pulses
//   o_rd_start, o_wr_start     one-cycle start pulses to the masters
//   o_rd_src_addr, o_wr_dst_addr, o_xfer_len
//                              latched descriptor, held until next grant
//   i_rd_done, i_wr_done       master done levels
//   o_irq, i_irq_clr           sticky interrupt and its clear
//   o_hung                     sticky timeout flag, blocks further grants
//   o_bytes_total              sum of lengths of successful transfers
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | arbitrate between requesting channels, check descriptor
// LAUNCH | start pulses on the outputs, clear done-seen flags and timer
// WAIT   | collect rising edges of both master done levels, run timer
// DONE   | done pulse out, byte count updated, return to IDLE
// ERR    | err pulse out (bad descriptor or timeout), return to IDLE

module dma_channel_scheduler #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_ch0_req,
  input  logic [31:0] i_ch0_src_addr,
  input  logic [31:0] i_ch0_dst_addr,
  input  logic [31:0] i_ch0_len,
  input  logic        i_ch1_req,
  input  logic [31:0] i_ch1_src_addr,
  input  logic [31:0] i_ch1_dst_addr,
  input  logic [31:0] i_ch1_len,
  output logic        o_ch0_busy,
  output logic        o_ch0_done,
  output logic        o_ch0_err,
  output logic        o_ch1_busy,
  output logic        o_ch1_done,
  output logic        o_ch1_err,
  output logic        o_rd_start,
  output logic        o_wr_start,
  output logic [31:0] o_rd_src_addr,
  output logic [31:0] o_wr_dst_addr,
  output logic [31:0] o_xfer_len,
  input  logic        i_rd_done,
  input  logic        i_wr_done,
  output logic        o_irq,
  input  logic        i_irq_clr,
  output logic        o_hung,
  output logic [31:0] o_bytes_total
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_DONE   = 3'd3,
    S_ERR    = 3'd4
  } state_t;

  state_t      r_state;
  logic        r_last_grant;
  logic        r_gnt_id;
  logic [31:0] r_src;
  logic [31:0] r_dst;
  logic [31:0] r_len;
  logic [31:0] r_bytes;
  logic [31:0] r_tmo_cnt;
  logic        r_rd_done_q;
  logic        r_wr_done_q;
  logic        r_rd_seen;
  logic        r_wr_seen;
  logic [1:0]  r_busy;
  logic [1:0]  r_done;
  logic [1:0]  r_err;
  logic        r_rd_start;
  logic        r_wr_start;
  logic        r_irq;
  logic        r_hung;

  logic        w_gnt_valid;
  logic        w_gnt_id;
  logic [31:0] w_src;
  logic [31:0] w_dst;
  logic [31:0] w_len;
  logic        w_desc_ok;
  logic        w_rd_rise;
  logic        w_wr_rise;
  logic        w_both_seen;
  logic [31:0] w_tmo_next;
  logic        w_tmo_hit;

  // On a tie the channel that did not win last time gets the engine.
  assign w_gnt_valid = ~r_hung & (i_ch0_req | i_ch1_req);
  assign w_gnt_id    = (i_ch0_req & i_ch1_req) ? ~r_last_grant : i_ch1_req;

  assign w_src = w_gnt_id ? i_ch1_src_addr : i_ch0_src_addr;
  assign w_dst = w_gnt_id ? i_ch1_dst_addr : i_ch0_dst_addr;
  assign w_len = w_gnt_id ? i_ch1_len      : i_ch0_len;

  assign w_desc_ok = (w_len != 32'd0) && (w_len[1:0] == 2'b00) &&
                     (w_src[1:0] == 2'b00) && (w_dst[1:0] == 2'b00);

  // Done levels from the previous transfer are still high at launch, so
  // only a fresh low-to-high transition counts as completion.
  assign w_rd_rise   = i_rd_done & ~r_rd_done_q;
  assign w_wr_rise   = i_wr_done & ~r_wr_done_q;
  assign w_both_seen = (r_rd_seen | w_rd_rise) & (r_wr_seen | w_wr_rise);

  assign w_tmo_next = r_tmo_cnt + 32'd1;
  assign w_tmo_hit  = (w_tmo_next >= TIMEOUT_CYCLES);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_gnt_id     <= 1'b0;
      r_src        <= 32'd0;
      r_dst        <= 32'd0;
      r_len        <= 32'd0;
      r_bytes      <= 32'd0;
      r_tmo_cnt    <= 32'd0;
      r_rd_done_q  <= 1'b0;
      r_wr_done_q  <= 1'b0;
      r_rd_seen    <= 1'b0;
      r_wr_seen    <= 1'b0;
      r_busy       <= 2'b00;
      r_done       <= 2'b00;
      r_err        <= 2'b00;
      r_rd_start   <= 1'b0;
      r_wr_start   <= 1'b0;
      r_irq        <= 1'b0;
      r_hung       <= 1'b0;
    end else begin
      r_rd_done_q <= i_rd_done;
      r_wr_done_q <= i_wr_done;
      r_rd_start  <= 1'b0;
      r_wr_start  <= 1'b0;
      r_done      <= 2'b00;
      r_err       <= 2'b00;

      // Any set below is written later in this block, so a set landing
      // together with a clear leaves the interrupt asserted.
      if (i_irq_clr) begin
        r_irq <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (w_gnt_valid) begin
            r_src        <= w_src;
            r_dst        <= w_dst;
            r_len        <= w_len;
            r_gnt_id     <= w_gnt_id;
            r_last_grant <= w_gnt_id;
            if (w_desc_ok) begin
              r_state            <= S_LAUNCH;
              r_rd_start         <= 1'b1;
              r_wr_start         <= 1'b1;
              r_busy[w_gnt_id]   <= 1'b1;
            end else begin
              r_state          <= S_ERR;
              r_err[w_gnt_id]  <= 1'b1;
              r_irq            <= 1'b1;
            end
          end
        end

        S_LAUNCH: begin
          r_rd_seen <= 1'b0;
          r_wr_seen <= 1'b0;
          r_tmo_cnt <= 32'd0;
          r_state   <= S_WAIT;
        end

        S_WAIT: begin
          if (w_rd_rise) begin
            r_rd_seen <= 1'b1;
          end
          if (w_wr_rise) begin
            r_wr_seen <= 1'b1;
          end
          // Completion wins over a timeout reached in the same cycle.
          if (w_both_seen) begin
            r_state          <= S_DONE;
            r_done[r_gnt_id] <= 1'b1;
            r_irq            <= 1'b1;
          end else begin
            r_tmo_cnt <= w_tmo_next;
            if (w_tmo_hit) begin
              r_state         <= S_ERR;
              r_err[r_gnt_id] <= 1'b1;
              r_busy          <= 2'b00;
              r_hung          <= 1'b1;
              r_irq           <= 1'b1;
            end
          end
        end

        S_DONE: begin
          r_bytes <= r_bytes + r_len;
          r_irq   <= 1'b1;
          r_busy  <= 2'b00;
          r_state <= S_IDLE;
        end

        S_ERR: begin
          r_irq   <= 1'b1;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_ch0_busy    = r_busy[0];
  assign o_ch1_busy    = r_busy[1];
  assign o_ch0_done    = r_done[0];
  assign o_ch1_done    = r_done[1];
  assign o_ch0_err     = r_err[0];
  assign o_ch1_err     = r_err[1];
  assign o_rd_start    = r_rd_start;
  assign o_wr_start    = r_wr_start;
  assign o_rd_src_addr = r_src;
  assign o_wr_dst_addr = r_dst;
  assign o_xfer_len    = r_len;
  assign o_irq         = r_irq;
  assign o_hung        = r_hung;
  assign o_bytes_total = r_bytes;

endmodule

// File: tb/tb_dma_channel_scheduler.sv
module tb_dma_channel_scheduler;

  localparam int TMO = 50;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_ch0_req, i_ch1_req;
  logic [31:0] i_ch0_src_addr, i_ch0_dst_addr, i_ch0_len;
  logic [31:0] i_ch1_src_addr, i_ch1_dst_addr, i_ch1_len;
  logic        o_ch0_busy, o_ch0_done, o_ch0_err;
  logic        o_ch1_busy, o_ch1_done, o_ch1_err;
  logic        o_rd_start, o_wr_start;
  logic [31:0] o_rd_src_addr, o_wr_dst_addr, o_xfer_len;
  logic        i_rd_done, i_wr_done;
  logic        o_irq, i_irq_clr, o_hung;
  logic [31:0] o_bytes_total;

  dma_channel_scheduler #(.TIMEOUT_CYCLES(32'd50)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_ch0_req(i_ch0_req), .i_ch0_src_addr(i_ch0_src_addr),
    .i_ch0_dst_addr(i_ch0_dst_addr), .i_ch0_len(i_ch0_len),
    .i_ch1_req(i_ch1_req), .i_ch1_src_addr(i_ch1_src_addr),
    .i_ch1_dst_addr(i_ch1_dst_addr), .i_ch1_len(i_ch1_len),
    .o_ch0_busy(o_ch0_busy), .o_ch0_done(o_ch0_done), .o_ch0_err(o_ch0_err),
    .o_ch1_busy(o_ch1_busy), .o_ch1_done(o_ch1_done), .o_ch1_err(o_ch1_err),
    .o_rd_start(o_rd_start), .o_wr_start(o_wr_start),
    .o_rd_src_addr(o_rd_src_addr), .o_wr_dst_addr(o_wr_dst_addr),
    .o_xfer_len(o_xfer_len),
    .i_rd_done(i_rd_done), .i_wr_done(i_wr_done),
    .o_irq(o_irq), .i_irq_clr(i_irq_clr), .o_hung(o_hung),
    .o_bytes_total(o_bytes_total)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    logic [31:0] len;
  } desc_t;

  typedef struct {
    int          ch;
    bit          start;
    bit          done;
    bit          tmo;
    logic [31:0] src;
    logic [31:0] dst;
    logic [31:0] len;
  } sb_t;

  desc_t rq0[$], rq1[$];   // requester queues (drive req/descriptor)
  desc_t st0[$], st1[$];   // staging for the next batch
  sb_t   sb[$];            // expected outcomes, in grant order

  int          n_pass = 0;
  int          n_total = 0;
  int          m_last = 1;
  logic [31:0] m_bytes = 32'd0;

  bit clr_on_done = 1'b0;
  bit clr_manual  = 1'b0;
  bit wr_stuck    = 1'b0;
  int rd_fixed    = 0;
  int wr_fixed    = 0;
  int rd_rise_cyc = 0;
  int wr_rise_cyc = 0;
  bit started     = 1'b0;
  int start_cyc   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic bit desc_ok(input desc_t d);
    return (d.len != 0) && (d.len % 4 == 0) && (d.src % 4 == 0) && (d.dst % 4 == 0);
  endfunction

  function automatic desc_t mk(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l);
    desc_t r;
    r.src = s; r.dst = d; r.len = l;
    return r;
  endfunction

  function automatic desc_t rand_desc();
    desc_t d;
    int    r;
    d.src = $urandom & 32'hFFFF_FFFC;
    d.dst = $urandom & 32'hFFFF_FFFC;
    d.len = 32'($urandom_range(1, 64)) * 32'd4;
    r = $urandom_range(0, 9);
    if (r == 0) d.len = 32'd0;
    else if (r == 1) d.len = d.len + 32'd2;
    else if (r == 2) d.src = d.src + 32'd1;
    else if (r == 3) d.dst = d.dst + 32'd2;
    return d;
  endfunction

  // Reference model: round robin over the staged descriptors, the channel
  // that did not win last time takes a tie; invalid ones are rejected.
  task automatic issue_batch(input bit stuck);
    int i0 = 0;
    int i1 = 0;
    while (i0 < st0.size() || i1 < st1.size()) begin
      bit    h0, h1, ok;
      int    pick;
      desc_t d;
      sb_t   e;
      h0 = (i0 < st0.size());
      h1 = (i1 < st1.size());
      if (h0 && h1) pick = 1 - m_last;
      else pick = h0 ? 0 : 1;
      m_last = pick;
      if (pick == 1) begin d = st1[i1]; i1++; end
      else begin d = st0[i0]; i0++; end
      ok = desc_ok(d);
      e.ch = pick; e.start = ok; e.done = ok && !stuck; e.tmo = ok && stuck;
      e.src = d.src; e.dst = d.dst; e.len = d.len;
      sb.push_back(e);
      if (e.done) m_bytes = m_bytes + d.len;
    end
    foreach (st0[i]) rq0.push_back(st0[i]);
    foreach (st1[i]) rq1.push_back(st1[i]);
    st0.delete();
    st1.delete();
  endtask

  task automatic wait_drain(input int limit);
    int n = 0;
    while ((sb.size() + rq0.size() + rq1.size()) > 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (n >= limit) begin
      chk("drain_timeout", 32'(sb.size() + rq0.size() + rq1.size()), 32'd0);
      sb.delete(); rq0.delete(); rq1.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic clear_irq();
    @(posedge clk);
    clr_manual = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, 32'({o_ch0_busy, o_ch1_busy}), 32'd0);
    chk({tag, "_pulses"}, 32'({o_ch0_done, o_ch0_err, o_ch1_done, o_ch1_err,
                               o_rd_start, o_wr_start}), 32'd0);
    chk({tag, "_src"}, o_rd_src_addr, 32'd0);
    chk({tag, "_dst"}, o_wr_dst_addr, 32'd0);
    chk({tag, "_len"}, o_xfer_len, 32'd0);
    chk({tag, "_irq_hung"}, 32'({o_irq, o_hung}), 32'd0);
    chk({tag, "_bytes"}, o_bytes_total, 32'd0);
  endtask

  // Requesters: req is high while a descriptor is queued; pop on done/err.
  initial begin
    i_ch0_req = 0; i_ch1_req = 0;
    i_ch0_src_addr = 0; i_ch0_dst_addr = 0; i_ch0_len = 0;
    i_ch1_src_addr = 0; i_ch1_dst_addr = 0; i_ch1_len = 0;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if ((o_ch0_done || o_ch0_err) && rq0.size() > 0) void'(rq0.pop_front());
        if ((o_ch1_done || o_ch1_err) && rq1.size() > 0) void'(rq1.pop_front());
      end
      i_ch0_req = (rq0.size() > 0);
      i_ch1_req = (rq1.size() > 0);
      if (rq0.size() > 0) begin
        i_ch0_src_addr = rq0[0].src; i_ch0_dst_addr = rq0[0].dst; i_ch0_len = rq0[0].len;
      end else begin
        i_ch0_src_addr = $urandom; i_ch0_dst_addr = $urandom; i_ch0_len = $urandom;
      end
      if (rq1.size() > 0) begin
        i_ch1_src_addr = rq1[0].src; i_ch1_dst_addr = rq1[0].dst; i_ch1_len = rq1[0].len;
      end else begin
        i_ch1_src_addr = $urandom; i_ch1_dst_addr = $urandom; i_ch1_len = $urandom;
      end
    end
  end

  // Master models: done drops on start and rises d cycles later, then holds.
  initial begin
    int cnt = 0;
    i_rd_done = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        i_rd_done = 0; cnt = 0;
      end else if (o_rd_start) begin
        i_rd_done = 0;
        cnt = (rd_fixed > 0) ? rd_fixed : int'($urandom_range(1, 30));
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin i_rd_done = 1; rd_rise_cyc = cyc; end
      end
    end
  end

  initial begin
    int cnt = 0;
    i_wr_done = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        i_wr_done = 0; cnt = 0;
      end else if (o_wr_start) begin
        i_wr_done = 0;
        if (wr_stuck) cnt = 0;
        else cnt = (wr_fixed > 0) ? wr_fixed : int'($urandom_range(1, 30));
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin i_wr_done = 1; wr_rise_cyc = cyc; end
      end
    end
  end

  initial begin
    i_irq_clr = 0;
    forever begin
      @(negedge clk);
      i_irq_clr = clr_manual || (clr_on_done && (o_ch0_done || o_ch1_done));
      clr_manual = 1'b0;
    end
  end

  // Monitor / scoreboard checker.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n) begin
        int np;
        chk("busy_exclusive", 32'(o_ch0_busy & o_ch1_busy), 32'd0);
        if (o_rd_start || o_wr_start) begin
          chk("rd_start", 32'(o_rd_start), 32'd1);
          chk("wr_start", 32'(o_wr_start), 32'd1);
          chk("start_expected", 32'(sb.size() > 0 && sb[0].start && !started), 32'd1);
          if (sb.size() > 0) begin
            chk("start_src", o_rd_src_addr, sb[0].src);
            chk("start_dst", o_wr_dst_addr, sb[0].dst);
            chk("start_len", o_xfer_len, sb[0].len);
            chk("busy_at_start", 32'((sb[0].ch == 1) ? o_ch1_busy : o_ch0_busy), 32'd1);
          end
          started = 1'b1;
          start_cyc = cyc;
        end
        np = int'(o_ch0_done) + int'(o_ch0_err) + int'(o_ch1_done) + int'(o_ch1_err);
        if (np > 0) begin
          chk("one_pulse", 32'(np), 32'd1);
          chk("pulse_expected", 32'(sb.size() > 0), 32'd1);
          if (sb.size() > 0) begin
            sb_t e;
            bit  act_done;
            e = sb.pop_front();
            act_done = o_ch0_done | o_ch1_done;
            chk("grant_ch", 32'(o_ch1_done | o_ch1_err), 32'(e.ch));
            chk("outcome_done", 32'(act_done), 32'(e.done));
            chk("started", 32'(started), 32'(e.start));
            if (act_done) begin
              chk("done_latency", 32'(cyc),
                  32'(((rd_rise_cyc > wr_rise_cyc) ? rd_rise_cyc : wr_rise_cyc) + 1));
              chk("busy_in_done", 32'((e.ch == 1) ? o_ch1_busy : o_ch0_busy), 32'd1);
            end else begin
              chk("busy_in_err", 32'(o_ch0_busy | o_ch1_busy), 32'd0);
            end
            if (e.tmo) begin
              chk("timeout_latency", 32'(cyc), 32'(start_cyc + TMO + 1));
              chk("hung_set", 32'(o_hung), 32'd1);
            end
          end
          started = 1'b0;
        end
      end
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed so far", n_pass, n_total);
    $fatal(1);
  end

  initial begin
    int n;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset_n = 1'b1;
    @(negedge clk);
    check_all_zero("post_reset");

    // Five back-to-back rounds with both channels requesting.
    for (int i = 0; i < 3; i++) st0.push_back(mk(32'h100 * i, 32'h4000 + 32'h100 * i, 32'd16));
    for (int i = 0; i < 2; i++) st1.push_back(mk(32'h2000 + 32'h100 * i, 32'h6000, 32'd16));
    issue_batch(1'b0);
    wait_drain(600);
    chk("rr_bytes", o_bytes_total, m_bytes);
    chk("rr_irq", 32'(o_irq), 32'd1);

    // Single ch0 transfer with fixed master latencies.
    rd_fixed = 20; wr_fixed = 25;
    st0.push_back(mk(32'h1000, 32'h8000, 32'd64));
    issue_batch(1'b0);
    wait_drain(200);
    chk("single_bytes", o_bytes_total, m_bytes);
    chk("single_irq", 32'(o_irq), 32'd1);
    rd_fixed = 0; wr_fixed = 0;

    // Rejected descriptors on ch1.
    clear_irq();
    chk("irq_cleared", 32'(o_irq), 32'd0);
    st1.push_back(mk(32'h3000, 32'h9000, 32'd6));
    st1.push_back(mk(32'h3000, 32'h9000, 32'd0));
    st1.push_back(mk(32'h3000, 32'h8002, 32'd16));
    issue_batch(1'b0);
    wait_drain(100);
    chk("err_bytes_unchanged", o_bytes_total, m_bytes);
    chk("err_irq", 32'(o_irq), 32'd1);

    // Interrupt clear coinciding with the done pulse.
    clear_irq();
    chk("irq_cleared2", 32'(o_irq), 32'd0);
    clr_on_done = 1'b1;
    st0.push_back(mk(32'h500, 32'h700, 32'd32));
    issue_batch(1'b0);
    wait_drain(200);
    chk("irq_set_wins", 32'(o_irq), 32'd1);
    clr_on_done = 1'b0;

    // Randomized batches.
    for (int b = 0; b < 8; b++) begin
      int k0, k1;
      k0 = $urandom_range(0, 3);
      k1 = $urandom_range(0, 3);
      for (int i = 0; i < k0; i++) st0.push_back(rand_desc());
      for (int i = 0; i < k1; i++) st1.push_back(rand_desc());
      issue_batch(1'b0);
      wait_drain(800);
      chk("rand_bytes", o_bytes_total, m_bytes);
    end

    // Reset asserted while a transfer is in WAIT.
    wr_stuck = 1'b1;
    st0.push_back(mk(32'h40, 32'h80, 32'd8));
    issue_batch(1'b1);
    n = 0;
    while (!(started && cyc >= start_cyc + 5) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("in_wait_busy", 32'(o_ch0_busy), 32'd1);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    rq0.delete(); rq1.delete(); sb.delete(); started = 1'b0;
    #1;
    check_all_zero("mid_reset");
    repeat (2) @(negedge clk);
    m_last = 1; m_bytes = 32'd0; wr_stuck = 1'b0;
    reset_n = 1'b1;
    st1.push_back(mk(32'hA0, 32'hB0, 32'd12));
    issue_batch(1'b0);
    wait_drain(200);
    chk("after_reset_bytes", o_bytes_total, m_bytes);

    // Timeout: write master never completes.
    wr_stuck = 1'b1;
    st0.push_back(mk(32'h10, 32'h20, 32'd4));
    issue_batch(1'b1);
    wait_drain(300);
    chk("hung_flag", 32'(o_hung), 32'd1);
    wr_stuck = 1'b0;
    rq1.push_back(mk(32'h30, 32'h40, 32'd4));
    repeat (120) @(negedge clk);
    chk("hung_no_grant", 32'(o_ch1_busy), 32'd0);
    chk("hung_req_pending", 32'(rq1.size()), 32'd1);
    chk("hung_sticky", 32'(o_hung), 32'd1);
    rq1.delete();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("hung_cleared", 32'(o_hung), 32'd0);
    m_last = 1; m_bytes = 32'd0;
    reset_n = 1'b1;
    st1.push_back(mk(32'h30, 32'h40, 32'd4));
    issue_batch(1'b0);
    wait_drain(200);
    chk("post_hung_bytes", o_bytes_total, m_bytes);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
